adder_result_stage: RTL and testbench

//  Registered output stage fed directly by the 32-bit carry-increment adder (sum, cout, of).

---
 rtl/adder_result_stage.sv | 193 +++++++++++++++++++
 tb/tb_adder_result_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/adder_result_stage.sv
// Registered result stage behind the 32-bit carry-increment adder.
// Captures sum/cout/of with a valid/ready handshake, derives NZCV flags at capture
// and holds up to two results (head + skid) so back-pressure never drops a sum.
// A saturating counter tallies accepted results that carried signed overflow.
module adder_result_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   // Adder side
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             cout_in,
   input  logic             of_in,
   // Consumer side
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       flags,
   // Debug counter
   output logic [CNT_W-1:0] of_count,
   input  logic             clr_count
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   // State encodes buffer occupancy directly.
   typedef enum logic [1:0] {
      StEmpty,
      StOne,
      StTwo
   } state_e;

   state_e state_q, state_d;

   logic             accept;
   logic             pop;
   logic [3:0]       in_flags;

   logic             head_load;
   logic             head_from_skid;
   logic             skid_load;

   logic [WIDTH-1:0] head_res_q, head_res_d;
   logic [3:0]       head_flags_q, head_flags_d;
   logic [WIDTH-1:0] skid_res_q, skid_res_d;
   logic [3:0]       skid_flags_q, skid_flags_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // {N, Z, C, V} of the incoming adder result
   assign in_flags = {sum_in[WIDTH-1], (sum_in == '0), cout_in, of_in};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus the entry load selects that go with each transition
   always_comb begin
      state_d        = state_q;
      head_load      = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d   = StOne;
               head_load = 1'b1;
            end
         end
         StOne: begin
            if (accept && pop) begin
               head_load = 1'b1;
            end else if (accept) begin
               state_d   = StTwo;
               skid_load = 1'b1;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            // in_ready is low here, so accept can never be set
            if (pop) begin
               state_d        = StOne;
               head_from_skid = 1'b1;
            end
         end
         default: begin
            state_d = StEmpty;
         end
      endcase
   end

   // Handshake outputs decoded from the state register only
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      unique case (state_q)
         StEmpty: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
         StOne: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
         end
         StTwo: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Entry next values; registers hold unless a load is selected
   always_comb begin
      head_res_d   = head_res_q;
      head_flags_d = head_flags_q;
      skid_res_d   = skid_res_q;
      skid_flags_d = skid_flags_q;
      if (head_load) begin
         head_res_d   = sum_in;
         head_flags_d = in_flags;
      end else if (head_from_skid) begin
         head_res_d   = skid_res_q;
         head_flags_d = skid_flags_q;
      end
      if (skid_load) begin
         skid_res_d   = sum_in;
         skid_flags_d = in_flags;
      end
   end

   // Entry registers
   always_ff @(posedge clk) begin
      if (rst) begin
         head_res_q   <= '0;
         head_flags_q <= '0;
         skid_res_q   <= '0;
         skid_flags_q <= '0;
      end else begin
         head_res_q   <= head_res_d;
         head_flags_q <= head_flags_d;
         skid_res_q   <= skid_res_d;
         skid_flags_q <= skid_flags_d;
      end
   end

   // Overflow counter next value: clear wins, increment saturates at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clr_count) begin
         cnt_d = '0;
      end else if (accept && of_in && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Overflow counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign res      = head_res_q;
   assign flags    = head_flags_q;
   assign of_count = cnt_q;

   // Head must hold steady while the consumer stalls
   a_head_stable : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> ($stable(res) && $stable(flags)));

   // Only three encodings are ever reachable
   a_state_legal : assert property (@(posedge clk) disable iff (rst)
      (state_q inside {StEmpty, StOne, StTwo}));

endmodule

// File: tb/tb_adder_result_stage.sv
// Bench for adder_result_stage: directed vector table, then randomized traffic
// checked against a queue-based reference model.
module tb_adder_result_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] sum_in;
   logic        cout_in;
   logic        of_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] res;
   logic [3:0]  flags;
   logic [7:0]  of_count;
   logic        clr_count;

   int n_checks;
   int n_fail;

   adder_result_stage #(
      .WIDTH(32),
      .CNT_W(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .sum_in   (sum_in),
      .cout_in  (cout_in),
      .of_in    (of_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .res      (res),
      .flags    (flags),
      .of_count (of_count),
      .clr_count(clr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] sum;
      logic        cout;
      logic        of;
      logic        ordy;
      logic        clr;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_res;
      logic [3:0]  e_fl;
      logic [7:0]  e_cnt;
   } vec_t;

   localparam int NVec = 17;
   vec_t tbl[NVec];

   // Reference model: FIFO of {flags, sum} plus an integer counter
   logic [35:0] mq[$];
   int          m_cnt;

   function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] s,
                               input logic c, input logic o, input logic ordy,
                               input logic clr, input logic e_ov, input logic e_ir,
                               input logic [31:0] e_res, input logic [3:0] e_fl,
                               input logic [7:0] e_cnt);
      vec_t v;
      v.rst = r; v.iv = iv; v.sum = s; v.cout = c; v.of = o; v.ordy = ordy; v.clr = clr;
      v.e_ov = e_ov; v.e_ir = e_ir; v.e_res = e_res; v.e_fl = e_fl; v.e_cnt = e_cnt;
      return v;
   endfunction

   function automatic logic [3:0] ref_flags(input logic [31:0] s, input logic c,
                                            input logic o);
      return {s[31], (s == 32'd0), c, o};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [31:0] s, input logic c,
                        input logic o, input logic ordy, input logic clr);
      rst = r; in_valid = iv; sum_in = s; cout_in = c; of_in = o;
      out_ready = ordy; clr_count = clr;
   endtask

   // One model-checked cycle
   task automatic mcycle(input logic iv, input logic [31:0] s, input logic c, input logic o,
                         input logic ordy, input logic clr, input string tag);
      bit acc;
      bit pp;
      @(negedge clk);
      drive(1'b0, iv, s, c, o, ordy, clr);
      acc = iv && (mq.size() < 2);
      pp  = (mq.size() != 0) && ordy;
      @(posedge clk);
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back({ref_flags(s, c, o), s});
      if (clr) m_cnt = 0;
      else if (acc && o && m_cnt < 255) m_cnt++;
      #1;
      chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, mq.size() < 2});
      if (mq.size() != 0) begin
         chk({tag, " res"}, res, mq[0][31:0]);
         chk({tag, " flags"}, {28'd0, flags}, {28'd0, mq[0][35:32]});
      end
      chk({tag, " of_count"}, {24'd0, of_count}, m_cnt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      mq.delete();
      m_cnt = 0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_cnt    = 0;
      drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      //          rst iv  sum           c  o  ordy clr | ov ir res           fl       cnt
      tbl[0]  = mk(1, 0, 32'h0,        0, 0, 0, 0,    0, 1, 32'h0,        4'b0000, 8'd0);
      tbl[1]  = mk(1, 1, 32'hDEAD_BEEF, 1, 1, 0, 0,   0, 1, 32'h0,        4'b0000, 8'd0);
      tbl[2]  = mk(0, 1, 32'h0,        1, 0, 1, 0,    1, 1, 32'h0,        4'b0110, 8'd0);
      tbl[3]  = mk(0, 0, 32'h0,        0, 0, 1, 0,    0, 1, 32'h0,        4'b0110, 8'd0);
      tbl[4]  = mk(0, 1, 32'h8000_0001, 0, 0, 0, 0,   1, 1, 32'h8000_0001, 4'b1000, 8'd0);
      tbl[5]  = mk(0, 1, 32'h0000_0005, 0, 0, 0, 0,   1, 0, 32'h8000_0001, 4'b1000, 8'd0);
      tbl[6]  = mk(0, 1, 32'h0000_0007, 1, 1, 0, 0,   1, 0, 32'h8000_0001, 4'b1000, 8'd0);
      tbl[7]  = mk(0, 1, 32'h0000_0007, 1, 1, 1, 0,   1, 1, 32'h0000_0005, 4'b0000, 8'd0);
      tbl[8]  = mk(0, 1, 32'h0000_0007, 1, 1, 1, 0,   1, 1, 32'h0000_0007, 4'b0011, 8'd1);
      tbl[9]  = mk(0, 0, 32'h0,        0, 0, 1, 0,    0, 1, 32'h0000_0007, 4'b0011, 8'd1);
      tbl[10] = mk(0, 1, 32'h0000_00AA, 0, 1, 0, 0,   1, 1, 32'h0000_00AA, 4'b0001, 8'd2);
      tbl[11] = mk(0, 1, 32'hFFFF_FFFF, 1, 1, 0, 0,   1, 0, 32'h0000_00AA, 4'b0001, 8'd3);
      tbl[12] = mk(1, 1, 32'h5555_5555, 0, 1, 0, 0,   0, 1, 32'h0,        4'b0000, 8'd0);
      tbl[13] = mk(0, 0, 32'h0,        0, 0, 1, 0,    0, 1, 32'h0,        4'b0000, 8'd0);
      tbl[14] = mk(0, 1, 32'h0000_0001, 0, 1, 0, 1,   1, 1, 32'h0000_0001, 4'b0001, 8'd0);
      tbl[15] = mk(0, 1, 32'h0000_0040, 0, 1, 1, 0,   1, 1, 32'h0000_0040, 4'b0001, 8'd1);
      tbl[16] = mk(0, 0, 32'h0,        0, 0, 1, 1,    0, 1, 32'h0000_0040, 4'b0001, 8'd0);

      for (int i = 0; i < NVec; i++) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].iv, tbl[i].sum, tbl[i].cout, tbl[i].of, tbl[i].ordy,
               tbl[i].clr);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
         chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
         chk($sformatf("vec%0d res", i), res, tbl[i].e_res);
         chk($sformatf("vec%0d flags", i), {28'd0, flags}, {28'd0, tbl[i].e_fl});
         chk($sformatf("vec%0d of_count", i), {24'd0, of_count}, {24'd0, tbl[i].e_cnt});
      end

      // Randomized traffic with back-pressure
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic [31:0] s;
         s = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
         mcycle(($urandom_range(0, 3) != 0), s, 1'($urandom()), 1'($urandom()),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0), "rand");
      end

      // Full-rate streaming: in_ready must never drop, order checked by the model
      do_reset();
      for (int i = 0; i < 100; i++) begin
         mcycle(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0, 1'b1, 1'b0, "stream");
      end

      // Counter saturation and clear-over-increment
      do_reset();
      for (int i = 0; i < 300; i++) begin
         mcycle(1'b1, $urandom(), 1'b1, 1'b1, 1'b1, 1'b0, "sat");
      end
      chk("sat final of_count", {24'd0, of_count}, 32'd255);
      mcycle(1'b1, 32'h0000_0123, 1'b0, 1'b1, 1'b1, 1'b1, "clr");
      chk("clr with accept of_count", {24'd0, of_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
